im_fetch_arb: RTL

IM_FETCH_ARB -- requirements
Module: im_fetch_arb

---
 rtl/im_arb_pkg.sv | 23 ++
 rtl/im_arb_fair_cnt.sv | 44 ++++
 rtl/im_fetch_arb.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/im_arb_pkg.sv
// im_arb_pkg -- shared definitions for the instruction-memory fetch/load arbiter.
//   arb_state_e    : arbiter FSM states (IDLE, FETCH_RSP, LOAD_ACK)
//   DEF_ADDR_BITS  : default word-address width into instruction memory
//   DEF_LOAD_BURST : default number of back-to-back load grants a waiting fetch tolerates
//   addr_bad()     : true for a misaligned byte address or one with bits above the memory
package im_arb_pkg;

    localparam int unsigned DEF_ADDR_BITS  = 10;
    localparam int unsigned DEF_LOAD_BURST = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FETCH_RSP = 2'd1,
        LOAD_ACK  = 2'd2
    } arb_state_e;

    function automatic logic addr_bad(input logic [31:0] addr, input int unsigned abits);
        logic [31:0] hi;
        hi = addr >> (abits + 2);
        return (addr[1:0] != 2'b00) || (hi != 32'd0);
    endfunction

endpackage

// File: rtl/im_arb_fair_cnt.sv
// im_arb_fair_cnt -- saturating starvation counter for the fetch requester.
// Counts load grants issued while a fetch is waiting; saturates at LOAD_BURST.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset, clears the count
//   inc   : a load was granted while a fetch was pending
//   clr   : fetch granted, or no fetch pending in IDLE (clear has priority)
//   sat   : count has reached LOAD_BURST
module im_arb_fair_cnt
    import im_arb_pkg::*;
#(
    parameter int unsigned LOAD_BURST = DEF_LOAD_BURST
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int unsigned CW = (LOAD_BURST < 1) ? 1 : $clog2(LOAD_BURST + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign sat = (cnt_q == CW'(LOAD_BURST));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !sat) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/im_fetch_arb.sv
// im_fetch_arb -- arbitrates one single-port, synchronous-read instruction memory between
// the CPU fetch port and the program-loader write port. Each transaction takes two cycles:
// a grant cycle in IDLE that drives the memory, then one response/ack cycle.
// Loads win ties until LOAD_BURST of them have been granted while a fetch waits.
// Ports:
//   clk, reset                    : clock; asynchronous active-low reset
//   if_req, if_pc                 : fetch request and byte PC
//   if_valid, if_instr            : one-cycle fetch response (if_instr is 0 when not valid)
//   ld_req, ld_addr, ld_data      : loader write request and payload
//   ld_ack                        : one-cycle loader acknowledge
//   mem_addr, mem_we, mem_wdata   : memory command (driven only in the grant cycle)
//   mem_rdata                     : memory read data, valid the cycle after the address
//   arb_err                       : sticky address-error flag
// Build option: define IM_ARB_ERR_EN to flag misaligned/out-of-range addresses on arb_err;
// such loads are acked without writing and such fetches return 0. Without it, addresses
// simply wrap and arb_err is tied to 0.
module im_fetch_arb
    import im_arb_pkg::*;
#(
    parameter int unsigned ADDR_BITS  = DEF_ADDR_BITS,
    parameter int unsigned LOAD_BURST = DEF_LOAD_BURST
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 if_req,
    input  logic [31:0]          if_pc,
    output logic                 if_valid,
    output logic [31:0]          if_instr,
    input  logic                 ld_req,
    input  logic [31:0]          ld_addr,
    input  logic [31:0]          ld_data,
    output logic                 ld_ack,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic                 mem_we,
    output logic [31:0]          mem_wdata,
    input  logic [31:0]          mem_rdata,
    output logic                 arb_err
);

    arb_state_e state_q, state_d;

    logic starve_sat;
    logic grant_ld, grant_if;
    logic cnt_inc, cnt_clr;
    logic ld_bad, if_bad;
    logic nop_q;

    // Byte-address bits that do not select a word; only consulted by the error check.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{ld_addr[31:ADDR_BITS+2], ld_addr[1:0],
                                if_pc[31:ADDR_BITS+2], if_pc[1:0]};

    // Grant decode: only IDLE samples requests, so in-flight transactions ignore them.
    always_comb begin
        grant_ld = 1'b0;
        grant_if = 1'b0;
        if (state_q == IDLE) begin
            if (ld_req && (!if_req || !starve_sat)) begin
                grant_ld = 1'b1;
            end else if (if_req) begin
                grant_if = 1'b1;
            end
        end
    end

    assign cnt_inc = grant_ld && if_req;
    assign cnt_clr = grant_if || ((state_q == IDLE) && !if_req);

    im_arb_fair_cnt #(
        .LOAD_BURST (LOAD_BURST)
    ) u_fair_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (cnt_inc),
        .clr   (cnt_clr),
        .sat   (starve_sat)
    );

`ifdef IM_ARB_ERR_EN
    logic err_q;

    assign ld_bad  = addr_bad(ld_addr, ADDR_BITS);
    assign if_bad  = addr_bad(if_pc, ADDR_BITS);
    assign arb_err = err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
            nop_q <= 1'b0;
        end else begin
            if ((grant_ld && ld_bad) || (grant_if && if_bad)) begin
                err_q <= 1'b1;
            end
            // Remembers that the fetch now in FETCH_RSP must return a nop.
            if (grant_if) begin
                nop_q <= if_bad;
            end
        end
    end
`else
    assign ld_bad  = 1'b0;
    assign if_bad  = 1'b0;
    assign nop_q   = 1'b0;
    assign arb_err = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE: begin
                if (grant_ld) begin
                    state_d = LOAD_ACK;
                end else if (grant_if) begin
                    state_d = FETCH_RSP;
                end
            end
            FETCH_RSP: state_d = IDLE;
            LOAD_ACK:  state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Outputs. Gated by reset so the memory command drops the instant reset asserts,
    // which also keeps a write issued in that cycle from landing.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if_valid  = 1'b0;
        if_instr  = '0;
        ld_ack    = 1'b0;
        if (reset) begin
            case (state_q)
                IDLE: begin
                    if (grant_ld) begin
                        mem_we    = !ld_bad;
                        mem_addr  = ld_addr[ADDR_BITS+1:2];
                        mem_wdata = ld_data;
                    end else if (grant_if) begin
                        mem_addr  = if_pc[ADDR_BITS+1:2];
                    end
                end
                FETCH_RSP: begin
                    if_valid = 1'b1;
                    if_instr = nop_q ? 32'd0 : mem_rdata;
                end
                LOAD_ACK: begin
                    ld_ack = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
